// File: rtl/frame_write_arbiter.sv
// rtl/frame_write_arbiter.sv - frame-granular round-robin arbiter in front of the BMP frame writer
// Optional wr_done watchdog enabled by defining FWA_TIMEOUT_EN.
module frame_write_arbiter #(
    parameter int WIDTH          = 768,
    parameter int HEIGHT         = 512,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        req0_frame,
    input  logic        req0_valid,
    input  logic [23:0] req0_rgb,
    output logic        req0_ready,
    input  logic        req1_frame,
    input  logic        req1_valid,
    input  logic [23:0] req1_rgb,
    output logic        req1_ready,
    output logic [1:0]  grant,
    output logic        wr_hsync,
    output logic [7:0]  wr_r,
    output logic [7:0]  wr_g,
    output logic [7:0]  wr_b,
    input  logic        wr_done,
    output logic        frame_done,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_GAP    = 2'd3;

    localparam logic [18:0] LAST_PIX = 19'(WIDTH * HEIGHT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 65536 || WIDTH * HEIGHT > 524288 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_param_check
        $error("frame_write_arbiter: illegal parameter set");
    end

    logic [1:0]  r_state;
    logic [1:0]  r_grant;
    logic [18:0] r_pix_cnt;
    logic [15:0] r_gap_cnt;
    logic        r_prefer1;
    logic        r_hsync;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;
    logic        r_frame_done;
    logic        r_busy;

    logic        w_stream;
    logic        w_beat;
    logic [23:0] w_rgb;
    logic [1:0]  w_pick;
    logic        w_timeout;

    assign w_stream   = (r_state == S_STREAM);
    assign req0_ready = w_stream & r_grant[0];
    assign req1_ready = w_stream & r_grant[1];
    assign w_beat     = (req0_ready & req0_valid) | (req1_ready & req1_valid);
    assign w_rgb      = r_grant[1] ? req1_rgb : req0_rgb;

    // r_prefer1 is set when req0 owned the previous frame, so req1 wins the next tie
    always_comb begin
        w_pick = 2'b00;
        if (req0_frame && req1_frame) begin
            w_pick = r_prefer1 ? 2'b10 : 2'b01;
        end else if (req0_frame) begin
            w_pick = 2'b01;
        end else if (req1_frame) begin
            w_pick = 2'b10;
        end
    end

`ifdef FWA_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_err;

    assign w_timeout   = (r_state == S_WAIT) && (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1));
    assign err_timeout = r_err;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wait_cnt <= 16'd0;
            r_err      <= 1'b0;
        end else if (r_state == S_WAIT && !wr_done) begin
            if (w_timeout) begin
                r_wait_cnt <= 16'd0;
                r_err      <= 1'b1;
            end else begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
        end else begin
            r_wait_cnt <= 16'd0;
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state      <= S_IDLE;
            r_grant      <= 2'b00;
            r_pix_cnt    <= 19'd0;
            r_gap_cnt    <= 16'd0;
            r_prefer1    <= 1'b0;
            r_hsync      <= 1'b0;
            r_r          <= 8'd0;
            r_g          <= 8'd0;
            r_b          <= 8'd0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_hsync      <= w_beat;
            r_frame_done <= 1'b0;
            if (w_beat) begin
                {r_r, r_g, r_b} <= w_rgb;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_pick != 2'b00) begin
                        r_grant   <= w_pick;
                        r_pix_cnt <= 19'd0;
                        r_busy    <= 1'b1;
                        r_state   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (w_beat) begin
                        if (r_pix_cnt == LAST_PIX) begin
                            r_pix_cnt <= 19'd0;
                            r_state   <= S_WAIT;
                        end else begin
                            r_pix_cnt <= r_pix_cnt + 19'd1;
                        end
                    end
                end
                S_WAIT: begin
                    // A watchdog release looks like a normal one except for the missing pulse
                    if (wr_done || w_timeout) begin
                        r_frame_done <= wr_done;
                        r_grant      <= 2'b00;
                        r_prefer1    <= r_grant[0];
                        r_gap_cnt    <= 16'd0;
                        r_state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant      = r_grant;
    assign wr_hsync   = r_hsync;
    assign wr_r       = r_r;
    assign wr_g       = r_g;
    assign wr_b       = r_b;
    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// tb/tb_frame_write_arbiter.sv - directed-vector bench for frame_write_arbiter (4x2 frame, gap 2)
module tb_frame_write_arbiter;

    localparam int NPIX = 8;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        req0_frame = 1'b0;
    logic        req0_valid = 1'b0;
    logic [23:0] req0_rgb = 24'd0;
    logic        req0_ready;
    logic        req1_frame = 1'b0;
    logic        req1_valid = 1'b0;
    logic [23:0] req1_rgb = 24'd0;
    logic        req1_ready;
    logic [1:0]  grant;
    logic        wr_hsync;
    logic [7:0]  wr_r;
    logic [7:0]  wr_g;
    logic [7:0]  wr_b;
    logic        wr_done = 1'b0;
    logic        frame_done;
    logic        busy;
    logic        err_timeout;

    int n_vec = 0;
    int n_err = 0;

    frame_write_arbiter #(
        .WIDTH(4), .HEIGHT(2), .GAP_CYCLES(2), .TIMEOUT_CYCLES(10)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req0_frame(req0_frame), .req0_valid(req0_valid), .req0_rgb(req0_rgb), .req0_ready(req0_ready),
        .req1_frame(req1_frame), .req1_valid(req1_valid), .req1_rgb(req1_rgb), .req1_ready(req1_ready),
        .grant(grant), .wr_hsync(wr_hsync), .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b),
        .wr_done(wr_done), .frame_done(frame_done), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The losing producer always presents a poisoned valid beat
    task automatic drive(input int p, input logic v, input logic [23:0] d);
        if (p == 0) begin
            req0_valid = v; req0_rgb = d; req1_valid = 1'b1; req1_rgb = 24'hBADBAD;
        end else begin
            req1_valid = v; req1_rgb = d; req0_valid = 1'b1; req0_rgb = 24'hBADBAD;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_hsync"}, wr_hsync, 1'b0);
        check({tag, "_rgb"}, {wr_r, wr_g, wr_b}, 24'd0);
        check({tag, "_ready0"}, req0_ready, 1'b0);
        check({tag, "_ready1"}, req1_ready, 1'b0);
        check({tag, "_frame_done"}, frame_done, 1'b0);
        check({tag, "_err"}, err_timeout, 1'b0);
    endtask

    task automatic stream_frame(input int p, input logic [23:0] base, input int stall_at,
                                input int stall_len, input int stop_at, input bit drop_req,
                                input bit stray_done);
        int idx = 0;
        int stalls = 0;
        int cyc = 0;
        logic v;
        logic [23:0] px;
        logic [23:0] last_px = 24'd0;
        while (idx < stop_at && cyc < 64) begin
            v = !(idx == stall_at && stalls < stall_len);
            if (!v) stalls++;
            px = base + 24'(idx + 1);
            drive(p, v, px);
            if (drop_req && idx == 4) begin
                if (p == 0) req0_frame = 1'b0; else req1_frame = 1'b0;
            end
            wr_done = stray_done && (idx == 1);
            check("ready_own", (p == 0) ? req0_ready : req1_ready, 1'b1);
            check("ready_other", (p == 0) ? req1_ready : req0_ready, 1'b0);
            @(negedge HCLK);
            check("hsync", wr_hsync, v);
            check("frame_done_in_stream", frame_done, 1'b0);
            if (v) begin
                check("rgb", {wr_r, wr_g, wr_b}, px);
                last_px = px;
                idx++;
            end else begin
                check("rgb_hold", {wr_r, wr_g, wr_b}, last_px);
            end
            cyc++;
        end
        wr_done = 1'b0;
        drive(p, 1'b0, 24'd0);
        check("stream_pixel_count", idx, stop_at);
        if (stop_at == NPIX) begin
            check("ready_after_last", (p == 0) ? req0_ready : req1_ready, 1'b0);
        end
    endtask

    task automatic release_frame();
        @(negedge HCLK);
        check("wait_hsync", wr_hsync, 1'b0);
        check("wait_frame_done", frame_done, 1'b0);
        check("wait_busy", busy, 1'b1);
        wr_done = 1'b1;
        @(negedge HCLK);
        wr_done = 1'b0;
        check("rel_frame_done", frame_done, 1'b1);
        check("rel_grant", grant, 2'b00);
        check("rel_busy", busy, 1'b1);
        @(negedge HCLK);
        check("gap_frame_done", frame_done, 1'b0);
        check("gap_busy", busy, 1'b1);
        @(negedge HCLK);
        check("idle_busy", busy, 1'b0);
        check("idle_grant", grant, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got hang expected finish");
        $fatal(1);
    end

    initial begin
        #1;
        check_reset_outputs("reset");
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Single producer, back-to-back pixels 1..8
        req0_frame = 1'b1;
        @(negedge HCLK);
        check("t1_grant", grant, 2'b01);
        check("t1_busy", busy, 1'b1);
        stream_frame(0, 24'h000000, 99, 0, NPIX, 1'b0, 1'b0);
        req0_frame = 1'b0;
        release_frame();
        @(negedge HCLK);
        check("t2_stay_idle", grant, 2'b00);

        // Both requesting from reset: req0, req1, req0
        HRESETn = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        req0_frame = 1'b1;
        req1_frame = 1'b1;
        @(negedge HCLK);
        check("t3_grant_a", grant, 2'b01);
        stream_frame(0, 24'h010000, 99, 0, NPIX, 1'b0, 1'b0);
        release_frame();
        @(negedge HCLK);
        check("t3_grant_b", grant, 2'b10);
        stream_frame(1, 24'h100000, 99, 0, NPIX, 1'b0, 1'b0);
        release_frame();
        @(negedge HCLK);
        check("t3_grant_c", grant, 2'b01);

        // Stall after pixel 3, drop req0_frame and a stray wr_done mid-frame
        stream_frame(0, 24'h200000, 3, 3, NPIX, 1'b1, 1'b1);
        release_frame();
        @(negedge HCLK);
        check("t4_grant_req1", grant, 2'b10);

        // Reset after pixel 5 of a req1 frame
        stream_frame(1, 24'h300000, 99, 0, 5, 1'b0, 1'b0);
        HRESETn = 1'b0;
        #1;
        check_reset_outputs("t5_async");
        req0_frame = 1'b1;
        @(negedge HCLK);
        check("t5_no_frame_done", frame_done, 1'b0);
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("t5_grant_req0", grant, 2'b01);
        stream_frame(0, 24'h400000, 99, 0, NPIX, 1'b0, 1'b0);

`ifdef FWA_TIMEOUT_EN
        for (int i = 0; i < 9; i++) begin
            @(negedge HCLK);
            check("t6_fd_wait", frame_done, 1'b0);
        end
        check("t6_grant_held", grant, 2'b01);
        check("t6_err_before", err_timeout, 1'b0);
        @(negedge HCLK);
        check("t6_grant_released", grant, 2'b00);
        check("t6_err_set", err_timeout, 1'b1);
        check("t6_no_frame_done", frame_done, 1'b0);
        @(negedge HCLK);
        check("t6_gap_busy", busy, 1'b1);
        @(negedge HCLK);
        check("t6_idle_busy", busy, 1'b0);
        @(negedge HCLK);
        check("t6_grant_other", grant, 2'b10);
        check("t6_err_sticky", err_timeout, 1'b1);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
        end
        check("t6_grant_held", grant, 2'b01);
        check("t6_busy_held", busy, 1'b1);
        check("t6_err_zero", err_timeout, 1'b0);
        release_frame();
        @(negedge HCLK);
        check("t6_grant_other", grant, 2'b10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/frame_write_arbiter.md
Name: frame_write_arbiter

Overview:
- Shares the single BMP frame-writer sink between two pixel-producing pipelines, e.g. the rotated-wafer path and a reference/debug path.
- Grants the sink for one whole frame at a time, using round-robin between the two producers.
- Forwards the granted stream as registered hsync/RGB beats and waits for the writer's done flag before releasing the sink.
- Sits between the processing pipelines and the writer.

Parameters:
WIDTH, 768, image width in pixels
HEIGHT, 512, image height in pixels
GAP_CYCLES, 4, idle cycles inserted after each completed frame (minimum 1)
TIMEOUT_CYCLES, 1024, wr_done wait limit; used only with FWA_TIMEOUT_EN

Ports:
HCLK  in  1  clock
HRESETn  in  1  asynchronous active-low reset
req0_frame  in  1  producer 0 requests a frame (level)
req0_valid  in  1  producer 0 pixel valid
req0_rgb  in  24  producer 0 pixel, {R[23:16],G[15:8],B[7:0]}
req0_ready  out  1  producer 0 pixel accepted when valid&ready
req1_frame  in  1  producer 1 frame request
req1_valid  in  1  producer 1 pixel valid
req1_rgb  in  24  producer 1 pixel
req1_ready  out  1  producer 1 ready
grant  out  2  one-hot owner of the sink; 00 when idle
wr_hsync  out  1  pixel strobe to writer
wr_r, wr_g, wr_b  out  8 each  pixel data to writer
wr_done  in  1  writer frame-complete flag
frame_done  out  1  one-cycle pulse per released frame
busy  out  1  high in every state except IDLE
err_timeout  out  1  sticky timeout flag (FWA_TIMEOUT_EN only, else 0)

Behaviour:
Clock, reset and registers:
- HCLK is the clock; HRESETn is the asynchronous active-low reset.
- All outputs are registered, except req*_ready, which is decoded combinationally from state and grant.
- Reset values: grant=00, wr_hsync=0, wr_r/g/b=0, frame_done=0, busy=0, err_timeout=0, req*_ready=0.
- Reset also clears state to IDLE, the pixel counter to 0 and the round-robin pointer to "prefer req0".

FSM:
- IDLE: if any reqN_frame is high, choose the owner and go to STREAM. Load grant on that same edge.
  - Only one request high: grant it.
  - Both high: grant the producer that was not granted last. After reset, req0 wins.
- STREAM:
  - reqN_ready=1 for the granted producer only; the other producer's ready=0.
  - On each accepted beat (valid&ready) the next edge sets wr_hsync=1 and wr_r/g/b = the accepted rgb bytes (1-cycle latency).
  - With no beat, wr_hsync=0 and RGB holds its last value.
  - A 19-bit pixel counter increments per beat.
  - The beat where counter==WIDTH*HEIGHT-1 is the last: ready drops on the following cycle, the counter clears, and the FSM goes to WAIT_DONE.
- WAIT_DONE:
  - ready=0, wr_hsync=0 (after the final beat is emitted).
  - On wr_done=1: frame_done pulses for one cycle, grant clears to 00, the pointer records the owner, and the FSM goes to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. busy stays 1 through GAP.

Boundary rules:
- Deasserting reqN_frame mid-frame is ignored; ownership is held until frame end.
- A valid stall (valid=0) inserts hsync bubbles; the frame does not abort.
- wr_done seen in IDLE, STREAM or GAP is ignored.
- A non-granted producer's valid/rgb never reach the writer.
- Asserting HRESETn low mid-frame immediately forces the reset values. A partially streamed frame is discarded (no frame_done) and arbitration restarts with req0 preferred.
- WIDTH*HEIGHT must be ≤ 2^19.

Optional Feature:
FWA_TIMEOUT_EN:
- Defined:
  - A 16-bit wait counter runs in WAIT_DONE.
  - If wr_done has not arrived after TIMEOUT_CYCLES cycles, the FSM goes to GAP without a frame_done pulse, and grant clears to 00.
  - The round-robin pointer is updated as for a normal release.
  - err_timeout sets and stays high until reset.
- Undefined: no counter; WAIT_DONE waits indefinitely; err_timeout is tied 0.

Test Plan:
(WIDTH=4, HEIGHT=2, GAP_CYCLES=2)
1. Reset → grant=00, busy=0, wr_hsync=0, all ready=0. Assert req0_frame with valid held high and rgb 0x000001..0x000008 → grant=01; 8 consecutive wr_hsync pulses with wr_b=1..8, each one cycle after acceptance; req0_ready low after the 8th beat.
2. Continue test 1: pulse wr_done → frame_done for exactly 1 cycle, grant=00, busy high for 2 further cycles, then IDLE.
3. req0_frame and req1_frame both high from reset → frames granted in order req0, req1, req0. req1_ready is never 1 while grant=01.
4. Drop req0_valid for 3 cycles after pixel 3 → exactly 3 hsync bubbles, still 8 total hsync pulses, pixel order preserved; deasserting req0_frame mid-frame has no effect.
5. Assert HRESETn low after pixel 5 of a req1 frame → outputs return to reset values immediately, no frame_done; next both-requesting arbitration grants req0.
6. With FWA_TIMEOUT_EN, TIMEOUT_CYCLES=10 and wr_done never asserted → release 10 cycles after the last beat, err_timeout=1 and stays 1, no frame_done, next frame granted to the other producer.
